// File: rtl/inst_ram256x8_pkg.sv
// Shared sizing constants for the instruction byte RAM.
// The top and the bus interface both take their defaults from here.
package mem_pkg;

    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int WORD_BYTES = WORD_W / BYTE_W;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/inst_ram256x8_if.sv
// Read/load bus for inst_ram256x8: combinational word fetch plus a byte
// write strobe used by the program loader.
interface inst_ram256x8_if #(
    parameter int AW = mem_pkg::AW
);
    logic [31:0]                 Address;
    logic                        Enable;
    logic [mem_pkg::WORD_W-1:0]  DataOut;
    logic                        we;
    logic [AW-1:0]               wr_addr;
    logic [mem_pkg::BYTE_W-1:0]  wr_data;

    modport master (
        output Address, Enable, we, wr_addr, wr_data,
        input  DataOut
    );

    modport slave (
        input  Address, Enable, we, wr_addr, wr_data,
        output DataOut
    );
endinterface

// File: rtl/inst_ram256x8.sv
// Byte-organised instruction RAM: big-endian 32-bit combinational fetch at any
// byte address (wrapping at the top), byte writes on the rising clock.
module inst_ram256x8 #(
    parameter int DEPTH = mem_pkg::DEPTH,
    parameter int AW    = mem_pkg::AW
) (
    output logic [mem_pkg::WORD_W-1:0] DataOut,
    input  logic [31:0]                Address,
    input  logic                       Enable,
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [AW-1:0]              wr_addr,
    input  logic [mem_pkg::BYTE_W-1:0] wr_data
);

    // Zero-filled at time 0; reset deliberately leaves contents alone so a
    // preloaded program survives it.
    mem_pkg::byte_t Mem [DEPTH] = '{default: '0};

    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[31:AW];

    // Gathers four consecutive bytes starting at a, first byte in the MSBs,
    // with the index wrapping modulo DEPTH.
    function automatic mem_pkg::word_t fetch_word(input logic [AW-1:0] a);
        mem_pkg::word_t w;
        int unsigned    idx;
        w = '0;
        for (int k = 0; k < mem_pkg::WORD_BYTES; k++) begin
            idx = (int'(a) + k) % DEPTH;
            w[mem_pkg::WORD_W-1-mem_pkg::BYTE_W*k -: mem_pkg::BYTE_W] = Mem[AW'(idx)];
        end
        return w;
    endfunction

    always_comb begin
        DataOut = '0;
        if (Enable)
            DataOut = fetch_word(Address[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset && we)
            Mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_inst_ram256x8.sv
// Directed bench for inst_ram256x8: program loading over the write port,
// aligned/unaligned/wrapped fetches, enable gating and reset behaviour.
module tb_inst_ram256x8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;

    inst_ram256x8_if bus ();

    inst_ram256x8 dut (
        .DataOut (bus.DataOut),
        .Address (bus.Address),
        .Enable  (bus.Enable),
        .clk     (clk),
        .reset   (reset),
        .we      (bus.we),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (bus.DataOut === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, bus.DataOut, exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic en,
                      input logic [31:0] exp);
        @(negedge clk);
        bus.Address = addr;
        bus.Enable  = en;
        #1;
        check(tag, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic rst);
        @(negedge clk);
        bus.we = 1'b1; bus.wr_addr = a; bus.wr_data = d; reset = rst;
        @(posedge clk);
        #1;
        bus.we = 1'b0; reset = 1'b0;
    endtask

    logic [7:0] prog [16] = '{8'hE3, 8'hA0, 8'h00, 8'h05, 8'hE2, 8'h80, 8'h10, 8'h01,
                              8'hEA, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        bus.Address = '0; bus.Enable = 1'b0;
        bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;

        rd("disabled_at_reset", 32'd0, 1'b0, 32'h0000_0000);
        rd("unwritten_zero", 32'd0, 1'b1, 32'h0000_0000);

        for (int i = 0; i < 16; i++) wr(8'(i), prog[i], 1'b0);

        rd("word0", 32'd0,  1'b1, 32'hE3A0_0005);
        rd("word4", 32'd4,  1'b1, 32'hE280_1001);
        rd("word8", 32'd8,  1'b1, 32'hEA00_0002);
        rd("word12", 32'd12, 1'b1, 32'h0000_0000);

        rd("enable_low", 32'd0, 1'b0, 32'h0000_0000);
        bus.Enable = 1'b1;
        #1;
        check("enable_rise", 32'hE3A0_0005);

        rd("unaligned1", 32'd1, 1'b1, 32'hA000_05E2);
        rd("upper_bits_ignored", 32'h0000_0100, 1'b1, 32'hE3A0_0005);

        wr(8'd253, 8'h11, 1'b0);
        wr(8'd254, 8'h22, 1'b0);
        wr(8'd255, 8'h33, 1'b0);
        rd("wrap253", 32'd253, 1'b1, 32'h1122_33E3);
        rd("wrap1FD", 32'h0000_01FD, 1'b1, 32'h1122_33E3);

        // Write blocked while reset is high.
        wr(8'd4, 8'hFF, 1'b1);
        rd("write_in_reset", 32'd4, 1'b1, 32'hE280_1001);

        // Same-cycle write and read: old byte before the edge, new after.
        @(negedge clk);
        bus.Address = 32'd4; bus.Enable = 1'b1;
        bus.we = 1'b1; bus.wr_addr = 8'd4; bus.wr_data = 8'hFF;
        #1;
        check("rdw_before_edge", 32'hE280_1001);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        check("rdw_after_edge", 32'hFF80_1001);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("during_reset_follows_mem", 32'hFF80_1001);
        reset = 1'b0;
        rd("after_reset_word0", 32'd0, 1'b1, 32'hE3A0_0005);
        rd("after_reset_word4", 32'd4, 1'b1, 32'hFF80_1001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/inst_ram256x8.md
INST_RAM256X8 -- requirements
Module: inst_ram256x8

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of byte locations.
REQ-003 Parameter AW, default 8, SHALL set the byte-index width; log2(DEPTH) = AW.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock for all sequential logic.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port DataOut, output, 32 bits, SHALL carry the instruction word read.
REQ-007 Port Address, input, 32 bits, SHALL carry the byte address of the word's first byte.
REQ-008 Port Enable, input, 1 bit, SHALL be the read enable.
REQ-009 Port we, input, 1 bit, SHALL be the byte-write strobe used for program loading.
REQ-010 Port wr_addr, input, AW bits, SHALL carry the byte index to write.
REQ-011 Port wr_data, input, 8 bits, SHALL carry the byte to write.
REQ-012 Port order SHALL be DataOut, Address, Enable first (positional instantiation), then clk, reset, we, wr_addr, wr_data.

Function
REQ-013 Storage SHALL be an array named Mem of DEPTH 8-bit entries, indices 0..DEPTH-1, hierarchically writable by benches (inst.Mem[i] = byte).
REQ-014 Only Address[AW-1:0] SHALL index Mem; upper address bits are ignored.
REQ-015 Read SHALL be combinational: with Enable=1, DataOut = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]} (big-endian, Mem[A] in bits 31:24), A = Address[AW-1:0].
REQ-016 Byte indices A+1..A+3 SHALL wrap modulo DEPTH (A=253 reads bytes 253,254,255,0).
REQ-017 Unaligned addresses SHALL be legal and read the four consecutive bytes starting at A.
REQ-018 With Enable=0, DataOut SHALL be 32'h0000_0000.
REQ-019 DataOut SHALL reflect Address, Enable or Mem changes within the same time step (zero-cycle latency).
REQ-020 On a rising clk with we=1 and reset=0, Mem[wr_addr] SHALL take wr_data.
REQ-021 A write and a read of the same byte in one cycle SHALL return the old byte before the edge and the new byte after it.
REQ-022 Unwritten locations SHALL read as 8'h00 in simulation (initialised at time 0).

Reset
REQ-023 While reset=1 at a rising clk, writes SHALL be suppressed.
REQ-024 Reset SHALL NOT clear Mem contents; preloaded programs survive reset.
REQ-025 DataOut has no state; during reset it SHALL follow REQ-015/REQ-018.

Structure
REQ-026 DEPTH, AW and word width (32) SHALL be constants in the shared package mem_pkg.
REQ-027 No sub-module; one optional helper function for word assembly with index wrap is allowed.

Verification
REQ-028 Preload Mem[0..15] = E3,A0,00,05, E2,80,10,01, EA,00,00,02, 00,00,00,00; Enable=1 at Address 0, 4, 8, 12 -> DataOut E3A00005, E2801001, EA000002, 00000000.
REQ-029 Enable=0 at Address 0 -> DataOut 00000000; raise Enable -> E3A00005 in the same time step.
REQ-030 Mem[253..255]=11,22,33, Mem[0]=E3; Address 253, Enable=1 -> 112233E3; Address 32'h0000_01FD -> same value.
REQ-031 Address 1 with the REQ-028 preload -> A00005E2.
REQ-032 we=1, wr_addr=4, wr_data=FF for one clk -> Address 4 reads FF801001 after the edge; same write with reset=1 -> unchanged E2801001.
REQ-033 Assert reset for 2 cycles after preload -> Address 0 still reads E3A00005.
